// File: rtl/mux_cfg_pkg.sv
// Shared opcodes, response codes and FSM state type for the console-mux configuration front end.
// Build option: MUX_CFG_READBACK_EN adds the RDBK state.
package mux_cfg_pkg;

   localparam logic [7:0] OP_SEL    = 8'h53;
   localparam logic [7:0] OP_EN     = 8'h45;
   localparam logic [7:0] OP_COMMIT = 8'h41;
   localparam logic [7:0] OP_READ   = 8'h52;

   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARG_SEL = 3'd1,
      ST_ARG_EN  = 3'd2,
`ifdef MUX_CFG_READBACK_EN
      ST_RESP    = 3'd3,
      ST_RDBK    = 3'd4
`else
      ST_RESP    = 3'd3
`endif
   } state_e;

endpackage

// File: rtl/mux_cfg_ctrl_if.sv
// Byte-stream link between the UART side and the configuration front end.
interface mux_cfg_ctrl_if;
   // Both directions use valid/ready: a byte moves on a rising edge where valid && ready;
   // the sender holds data and valid stable until that edge.
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/mux_cfg_timeout.sv
// Argument-wait watchdog: counts enabled cycles since the last clear and flags expiry.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module mux_cfg_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int               CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit               ACTIVE = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] LAST   = ACTIVE ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturates at LAST so a stalled enable can never wrap into a false second expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && ACTIVE && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = ACTIVE && en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mux_cfg_ctrl.sv
// Command parser that stages mux selector/enable changes in shadow registers and applies them on commit.
// Build option: MUX_CFG_READBACK_EN enables the 'R' readback stream of the live configuration.
module mux_cfg_ctrl
   import mux_cfg_pkg::*;
#(
   parameter  int INPUT_COUNT    = 4,
   parameter  int OUTPUT_COUNT   = 4,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int SEL_WIDTH      = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   mux_cfg_ctrl_if.slave                     bus,
   output logic [SEL_WIDTH*OUTPUT_COUNT-1:0] selectors,
   output logic [OUTPUT_COUNT-1:0]           enabled_out,
   output state_e                            dbg_state_o
);

   state_e                            state_q;
   logic [SEL_WIDTH*OUTPUT_COUNT-1:0] sel_q;
   logic [SEL_WIDTH*OUTPUT_COUNT-1:0] shadow_sel_q;
   logic [OUTPUT_COUNT-1:0]           en_q;
   logic [OUTPUT_COUNT-1:0]           shadow_en_q;
   logic [7:0]                        tx_data_q;
   logic                              tx_valid_q;
   logic                              rx_fire;
   logic                              in_arg;
   logic                              arg_in_range;
   logic                              tmo_expire;

`ifdef MUX_CFG_READBACK_EN
   localparam int IDX_W = $clog2(OUTPUT_COUNT + 1);
   logic [IDX_W-1:0] rdbk_idx_q;
`endif

   assign bus.rx_ready = (state_q == ST_IDLE) || (state_q == ST_ARG_SEL) || (state_q == ST_ARG_EN);
   assign rx_fire      = bus.rx_valid && bus.rx_ready;
   assign in_arg       = (state_q == ST_ARG_SEL) || (state_q == ST_ARG_EN);
   assign arg_in_range = (int'(bus.rx_data[7:4]) < OUTPUT_COUNT) &&
                         (int'(bus.rx_data[3:0]) < INPUT_COUNT);

   mux_cfg_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (rx_fire),
      .en_i     (in_arg),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         shadow_sel_q <= '0;
         en_q         <= '0;
         shadow_en_q  <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
`ifdef MUX_CFG_READBACK_EN
         rdbk_idx_q   <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_fire) begin
                  case (bus.rx_data)
                     OP_SEL: state_q <= ST_ARG_SEL;
                     OP_EN:  state_q <= ST_ARG_EN;
                     OP_COMMIT: begin
                        // The whole routing moves on this one edge so the mux never sees a mix.
                        sel_q      <= shadow_sel_q;
                        en_q       <= shadow_en_q;
                        tx_data_q  <= RSP_ACK;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_RESP;
                     end
`ifdef MUX_CFG_READBACK_EN
                     OP_READ: begin
                        tx_data_q  <= 8'(en_q);
                        tx_valid_q <= 1'b1;
                        rdbk_idx_q <= '0;
                        state_q    <= ST_RDBK;
                     end
`endif
                     default: begin
                        tx_data_q  <= RSP_NAK;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_RESP;
                     end
                  endcase
               end
            end

            ST_ARG_SEL: begin
               if (rx_fire) begin
                  if (arg_in_range) begin
                     for (int k = 0; k < OUTPUT_COUNT; k++) begin
                        if (int'(bus.rx_data[7:4]) == k) begin
                           shadow_sel_q[k*SEL_WIDTH +: SEL_WIDTH] <= bus.rx_data[SEL_WIDTH-1:0];
                        end
                     end
                  end
                  tx_data_q  <= arg_in_range ? RSP_ACK : RSP_NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_RESP;
               end else if (tmo_expire) begin
                  tx_data_q  <= RSP_NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end

            ST_ARG_EN: begin
               if (rx_fire) begin
                  shadow_en_q <= bus.rx_data[OUTPUT_COUNT-1:0];
                  tx_data_q   <= RSP_ACK;
                  tx_valid_q  <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (tmo_expire) begin
                  tx_data_q  <= RSP_NAK;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end

`ifdef MUX_CFG_READBACK_EN
            // rdbk_idx_q names the byte currently on tx: 0 is the enable mask, k+1 is selector k.
            ST_RDBK: begin
               if (bus.tx_ready) begin
                  if (rdbk_idx_q == IDX_W'(OUTPUT_COUNT)) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else begin
                     for (int k = 0; k < OUTPUT_COUNT; k++) begin
                        if (rdbk_idx_q == IDX_W'(k)) begin
                           tx_data_q <= 8'(sel_q[k*SEL_WIDTH +: SEL_WIDTH]);
                        end
                     end
                     rdbk_idx_q <= rdbk_idx_q + IDX_W'(1);
                  end
               end
            end
`endif

            default: begin
               tx_valid_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign selectors    = sel_q;
   assign enabled_out  = en_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mux_cfg_ctrl.sv
// Directed plus randomized bench for mux_cfg_ctrl against a command-level reference model.
module tb_mux_cfg_ctrl;
   import mux_cfg_pkg::*;

   localparam int IC  = 4;
   localparam int OC  = 4;
   localparam int SW  = 2;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW*OC-1:0] selectors;
   logic [OC-1:0] enabled_out;
   state_e        dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   // Reference model: shadow and live configuration as plain integers.
   int m_sh_sel[OC];
   int m_live_sel[OC];
   int m_sh_en;
   int m_live_en;

   always #5 clk = ~clk;

   mux_cfg_ctrl_if bus ();

   mux_cfg_ctrl #(
      .INPUT_COUNT    (IC),
      .OUTPUT_COUNT   (OC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .selectors   (selectors),
      .enabled_out (enabled_out),
      .dbg_state_o (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < OC; k++) begin
         m_sh_sel[k]   = 0;
         m_live_sel[k] = 0;
      end
      m_sh_en   = 0;
      m_live_en = 0;
   endfunction

   function automatic logic [7:0] model_cmd(input logic [7:0] op, input logic [7:0] arg);
      int o;
      int i;
      o = int'(arg) / 16;
      i = int'(arg) % 16;
      case (op)
         8'h53: begin
            if (o < OC && i < IC) begin
               m_sh_sel[o] = i;
               return 8'h06;
            end
            return 8'h15;
         end
         8'h45: begin
            m_sh_en = int'(arg) % (1 << OC);
            return 8'h06;
         end
         8'h41: begin
            for (int k = 0; k < OC; k++) m_live_sel[k] = m_sh_sel[k];
            m_live_en = m_sh_en;
            return 8'h06;
         end
         default: return 8'h15;
      endcase
   endfunction

   function automatic logic [31:0] model_sel();
      int acc = 0;
      for (int k = 0; k < OC; k++) acc += m_live_sel[k] * (1 << (k * SW));
      return 32'(acc);
   endfunction

   // Scoreboard: every tx handshake must match the oldest expected byte.
   always @(negedge clk) begin
      if (!rst && bus.tx_valid && bus.tx_ready) begin
         check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("sb_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      int   n;
      n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      do begin
         @(negedge clk);
         rdy = bus.rx_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 100);
      #1 bus.rx_valid = 1'b0;
      check("rx_accept", 32'(rdy), 32'd1);
   endtask

   // First negedge after the final byte: response must already be valid, commit already live.
   task automatic finish_rsp(input logic [7:0] exp, input int stall);
      @(negedge clk);
      check("rsp_valid", 32'(bus.tx_valid), 32'd1);
      check("live_sel", 32'(selectors), model_sel());
      check("live_en", 32'(enabled_out), 32'(m_live_en));
      if (stall > 0) begin
         for (int i = 0; i < stall; i++) begin
            check("rx_blocked", 32'(bus.rx_ready), 32'd0);
            check("rsp_hold", 32'(bus.tx_data), 32'(exp));
            @(negedge clk);
         end
         @(posedge clk);
         #1 bus.tx_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rsp_done", 32'(bus.tx_valid), 32'd0);
      check("rx_ready_idle", 32'(bus.rx_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [7:0] arg, input int stall, input int gap);
      logic [7:0] exp;
      exp = model_cmd(op, arg);
      exp_q.push_back(exp);
      if (stall > 0) bus.tx_ready = 1'b0;
      send_byte(op);
      if (op == 8'h53 || op == 8'h45) begin
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         send_byte(arg);
      end
      finish_rsp(exp, stall);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp;
      logic [7:0] op;
      logic [7:0] arg;
      int r;
      int n;

      model_reset();
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_sel", 32'(selectors), 32'h00);
      check("rst_en", 32'(enabled_out), 32'h0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h00);
      check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(posedge clk);
      #1;

      // Stage, then commit
      run_cmd(8'h53, 8'h12, 0, 0);
      run_cmd(8'h45, 8'h03, 0, 0);
      check("staged_sel", 32'(selectors), 32'h00);
      run_cmd(8'h41, 8'h00, 0, 0);
      check("commit_sel", 32'(selectors), 32'h08);
      check("commit_en", 32'(enabled_out), 32'h3);

      // Out-of-range selector arguments
      run_cmd(8'h53, 8'h41, 0, 0);
      run_cmd(8'h41, 8'h00, 0, 0);
      check("oor_sel_kept", 32'(selectors), 32'h08);
      run_cmd(8'h53, 8'h05, 0, 0);

      // Argument timeout
      exp_q.push_back(8'h15);
      send_byte(8'h53);
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         check("tmo_wait", 32'(bus.tx_valid), 32'd0);
      end
      @(negedge clk);
      check("tmo_nak", 32'(bus.tx_valid), 32'd1);
      check("tmo_nak_data", 32'(bus.tx_data), 32'h15);
      @(posedge clk);
      #1;
      run_cmd(8'h41, 8'h00, 0, 0);
      check("tmo_shadow_kept", 32'(selectors), 32'h08);

      // Backpressure: response held, next byte waits
      exp = model_cmd(8'h45, 8'h03);
      exp_q.push_back(exp);
      bus.tx_ready = 1'b0;
      send_byte(8'h45);
      send_byte(8'h03);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h41;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
         check("bp_tx_data", 32'(bus.tx_data), 32'h06);
         check("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus.tx_ready = 1'b1;
      exp = model_cmd(8'h41, 8'h00);
      exp_q.push_back(exp);
      send_byte(8'h41);
      finish_rsp(exp, 0);

      // Readback
`ifdef MUX_CFG_READBACK_EN
      exp_q.push_back(8'(m_live_en));
      for (int k = 0; k < OC; k++) exp_q.push_back(8'(m_live_sel[k]));
      send_byte(8'h52);
      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         @(negedge clk);
         #1;
         check("rdbk_rx_blocked", 32'(bus.rx_ready), 32'd0);
         n++;
      end
      check("rdbk_drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rdbk_done_valid", 32'(bus.tx_valid), 32'd0);
      check("rdbk_done_ready", 32'(bus.rx_ready), 32'd1);
      @(posedge clk);
      #1;
`else
      run_cmd(8'h52, 8'h00, 0, 0);
`endif

      // Randomized command stream
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            op  = 8'h53;
            arg = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 5));
         end else if (r <= 5) begin
            op  = 8'h45;
            arg = 8'($urandom_range(0, 255));
         end else if (r <= 7) begin
            op  = 8'h41;
            arg = 8'h00;
         end else begin
            op  = 8'($urandom_range(0, 255));
            arg = 8'h00;
            if (op == 8'h53 || op == 8'h45 || op == 8'h41 || op == 8'h52) op = 8'h00;
         end
         run_cmd(op, arg, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 int'($urandom_range(0, 4)));
      end

      // Reset with a response pending
      run_cmd(8'h53, 8'h13, 0, 0);
      run_cmd(8'h45, 8'h0F, 0, 0);
      run_cmd(8'h41, 8'h00, 0, 0);
      bus.tx_ready = 1'b0;
      send_byte(8'h45);
      send_byte(8'h05);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_sel", 32'(selectors), 32'h00);
      check("mid_rst_en", 32'(enabled_out), 32'h0);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      model_reset();
      bus.tx_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      run_cmd(8'h41, 8'h00, 0, 0);
      check("post_rst_sel", 32'(selectors), 32'h00);

      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
